mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's memory address path. It sits behind the address-source selector.
- Accepts one read or write request at a time on a valid/ready request channel.
- Services the request from an internal byte-addressed, big-endian data store after a fixed programmable wait.
- Returns read data or a write acknowledge on a valid/ready response channel, flagging misaligned or out-of-range accesses.

---
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding read/write request, serviced from a
// byte-addressed big-endian word store after a fixed wait, answered on a valid/ready channel.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EXEC,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        accept;

  logic        hold_write;
  logic [31:0] hold_addr;
  logic [1:0]  hold_size;
  logic [31:0] hold_wdata;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] rdata;
  logic [31:0] wmask;
  logic [31:0] wlane;
  logic [4:0]  sh;
  logic        illegal;

  assign accept = req_valid && req_ready;
  assign idx    = hold_addr[AW+1:2];
  assign word   = mem[idx];

  // NOTE: every flop below uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (LAT == 4'd0) ? S_EXEC : S_WAIT;
      S_WAIT: if (cnt == 4'd1) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
  end

  // Wait counter: loaded on acceptance, exits WAIT after exactly LATENCY cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (state == S_IDLE && accept) begin
      cnt <= LAT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_size  <= 2'b00;
      hold_wdata <= '0;
    end else if (state == S_IDLE && accept) begin
      hold_write <= req_write;
      hold_addr  <= req_addr;
      hold_size  <= req_size;
      hold_wdata <= req_wdata;
    end
  end

  always_comb begin
    illegal = 1'b0;
    case (hold_size)
      2'b00:   if (hold_addr[1:0] != 2'b00) illegal = 1'b1;
      2'b01:   if (hold_addr[0]) illegal = 1'b1;
      2'b10:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
    if ({1'b0, hold_addr} >= BYTES) illegal = 1'b1;
  end

  // Big-endian lanes: lower byte addresses land in more significant bits.
  always_comb begin
    rdata = '0;
    wmask = '0;
    wlane = '0;
    sh    = 5'd0;
    case (hold_size)
      2'b00: begin
        rdata = word;
        wmask = 32'hffff_ffff;
        wlane = hold_wdata;
      end
      2'b01: begin
        sh    = hold_addr[1] ? 5'd0 : 5'd16;
        rdata = {16'h0000, 16'(word >> sh)};
        wmask = 32'h0000_ffff << sh;
        wlane = {16'h0000, hold_wdata[15:0]} << sh;
      end
      2'b10: begin
        sh    = {~hold_addr[1:0], 3'b000};
        rdata = {24'h000000, 8'(word >> sh)};
        wmask = 32'h0000_00ff << sh;
        wlane = {24'h000000, hold_wdata[7:0]} << sh;
      end
      default: begin
        rdata = '0;
      end
    endcase
  end

  // NOTE: the store has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && hold_write && !illegal) begin
      mem[idx] <= (word & ~wmask) | (wlane & wmask);
    end
  end

  // Response is driven straight from flops; rsp_valid rises one cycle into RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= (state == S_RESP) && !(rsp_valid && rsp_ready);
      if (state == S_EXEC) begin
        rsp_error <= illegal;
        rsp_rdata <= (hold_write || illegal) ? 32'h0 : rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_error [2];

  int errors = 0;
  int checks = 0;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  // Runs one request with rsp_ready held by the caller; lat counts edges from acceptance.
  task automatic transact(input int u, input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic er);
    int n;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_size[u] = s; req_wdata[u] = d;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    lat = 0;
    while (rsp_valid[u] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata[u];
    er = rsp_error[u];
    checks++;
    if (rsp_valid[u] !== 1'b1) begin
      errors++;
      $display("FAIL response_timeout dut=%0d addr=%h: rsp_valid=%b, required 1", u, a, rsp_valid[u]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata[0]); end
    checks++; if (rsp_error[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw;
    int lat; logic [31:0] rd; logic er;
    transact(0, 1'b1, 32'h10, 2'b00, 32'h11223344, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL write_latency got=%0d exp=4", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_error got=%b exp=0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata got=%h exp=0", rd); end
    transact(0, 1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency got=%0d exp=4", lat); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL read_word got=%h exp=11223344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_error got=%b exp=0", er); end
  endtask

  task automatic test_lanes;
    int lat; logic [31:0] rd; logic er;
    transact(0, 1'b0, 32'h12, 2'b10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00000033) begin errors++; $display("FAIL read_byte_12 got=%h exp=00000033", rd); end
    transact(0, 1'b0, 32'h13, 2'b10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL read_byte_13 got=%h exp=00000044", rd); end
    transact(0, 1'b0, 32'h12, 2'b01, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL read_half_12 got=%h exp=00003344", rd); end
    transact(0, 1'b0, 32'h10, 2'b01, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00001122) begin errors++; $display("FAIL read_half_10 got=%h exp=00001122", rd); end
    transact(0, 1'b1, 32'h11, 2'b10, 32'hFFFFFFAA, lat, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_byte_error got=%b exp=0", er); end
    transact(0, 1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL byte_merge got=%h exp=11AA3344", rd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er;
    logic [31:0] addr_t [5] = '{32'h13, 32'h11, 32'h10, 32'h400, 32'h12};
    logic [1:0]  size_t [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    logic        wr_t   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      transact(0, wr_t[i], addr_t[i], size_t[i], 32'hFFFFFFFF, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_error_%0d got=%b exp=1", i, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL illegal_rdata_%0d got=%h exp=0", i, rd); end
    end
    transact(0, 1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL store_unchanged got=%h exp=11AA3344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL error_cleared got=%b exp=0", er); end
    transact(0, 1'b0, 32'h3FC, 2'b00, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_in_range got=%b exp=0", er); end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] rd; logic er;
    int n;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 2'b00;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got=%b exp=1", i, rsp_valid[0]); end
      checks++; if (rsp_rdata[0] !== 32'h11AA3344) begin errors++; $display("FAIL bp_rdata_%0d got=%h exp=11AA3344", i, rsp_rdata[0]); end
      checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready_%0d got=%b exp=0", i, req_ready[0]); end
      if (i == 1) begin
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10;
        req_size[0] = 2'b00; req_wdata[0] = 32'h0;
      end
      if (i == 2) req_valid[0] = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid[0]); end
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", req_ready[0]); end
    transact(0, 1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL bp_pulse_ignored got=%h exp=11AA3344", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic er;
    int n;
    transact(1, 1'b1, 32'h40, 2'b00, 32'h01020304, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lat0_write_latency got=%0d exp=2", lat); end
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h40; req_size[1] = 2'b00;
    @(posedge clk); #1;
    req_addr[1] = 32'h42; req_size[1] = 2'b01;
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_ready_e0 got=%b exp=0", req_ready[1]); end
    @(posedge clk); #1;
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_ready_e1 got=%b exp=0", req_ready[1]); end
    @(posedge clk); #1;
    checks++; if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got=%b exp=1", rsp_valid[1]); end
    checks++; if (rsp_rdata[1] !== 32'h01020304) begin errors++; $display("FAIL b2b_first_rdata got=%h exp=01020304", rsp_rdata[1]); end
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_ready_e2 got=%b exp=0", req_ready[1]); end
    @(posedge clk); #1;
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL b2b_first_drop got=%b exp=0", rsp_valid[1]); end
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_e3 got=%b exp=1", req_ready[1]); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b exp=0", req_ready[1]); end
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=2", n); end
    checks++; if (rsp_rdata[1] !== 32'h00000304) begin errors++; $display("FAIL b2b_second_rdata got=%h exp=00000304", rsp_rdata[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int lat; logic [31:0] rd; logic er;
    transact(0, 1'b1, 32'h20, 2'b00, 32'hCAFEF00D, lat, rd, er);
    transact(0, 1'b0, 32'h20, 2'b00, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_reset_read got=%h exp=CAFEF00D", rd); end
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_size[0] = 2'b00; req_wdata[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL midrst_rsp_rdata got=%h exp=0", rsp_rdata[0]); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    transact(0, 1'b0, 32'h20, 2'b00, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abandoned_write got=%h exp=CAFEF00D", rd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_size[i] = 2'b00; req_wdata[i] = '0; rsp_ready[i] = 1'b1;
    end
    test_reset;
    test_word_rw;
    test_lanes;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
